// File: rtl/food_machine_pkg.sv
// Shared definitions for the vending machine output side: product indices,
// dispenser state encoding and one-hot helpers.
package food_machine_pkg;

   localparam int PIZZA      = 0;
   localparam int BURGUER    = 1;
   localparam int TORTA      = 2;
   localparam int SODA       = 3;
   localparam int N_PRODUCTS = 4;
   localparam int IDX_W      = $clog2(N_PRODUCTS);

   typedef logic [IDX_W-1:0] prodIdx_t;

   typedef enum logic [1:0] {
      IDLE,
      DISPENSE,
      SETTLE,
      DONE
   } dispState_t;

   function automatic logic isOneHot(input logic [N_PRODUCTS-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   function automatic prodIdx_t oneHotIndex(input logic [N_PRODUCTS-1:0] v);
      prodIdx_t idx;
      idx = '0;
      for (int i = 0; i < N_PRODUCTS; i++) begin
         if (v[i]) idx = prodIdx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/dispenser_stock_counter.sv
// Per-product stock counter: saturating down-counter with synchronous load.
// A load coinciding with a decrement leaves the counter one below the load value.
module dispenser_stock_counter #(
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               dec,
   output logic [STOCK_W-1:0] count,
   output logic               zero
);

   localparam logic [STOCK_W-1:0] INIT_V     = STOCK_W'(STOCK_INIT);
   localparam logic [STOCK_W-1:0] INIT_DEC_V = (STOCK_INIT > 0) ? STOCK_W'(STOCK_INIT - 1) : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= INIT_V;
      end else if (load) begin
         count <= dec ? INIT_DEC_V : INIT_V;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/food_dispenser.sv
// Product dispenser: accepts qualified one-hot product strobes, runs one motor
// for a fixed time, then settles and pulses done. Optional one-deep pending
// request slot is enabled with the macro DISPENSER_PENDING_EN.
module food_dispenser
   import food_machine_pkg::*;
#(
   parameter int MOTOR_CYCLES  = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int STOCK_INIT    = 5,
   parameter int STOCK_W       = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          pizza,
   input  logic                          burguer,
   input  logic                          torta,
   input  logic                          soda,
   input  logic                          sucesso,
   input  logic                          reabastecer,
   output logic [N_PRODUCTS-1:0]         motor,
   output logic                          busy,
   output logic                          done,
   output logic [N_PRODUCTS-1:0]         esgotado,
   output logic                          erro,
   output logic [N_PRODUCTS*STOCK_W-1:0] estoque
);

   localparam int CNT_MAX = (MOTOR_CYCLES > SETTLE_CYCLES) ? MOTOR_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MOTOR_LAST  = CNT_W'(MOTOR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   dispState_t              state, nextState;
   logic [CNT_W-1:0]        phaseCnt;
   prodIdx_t                curIdx, reqIdx, acceptIdx, nextIdx;
   logic [N_PRODUCTS-1:0]   strobes, zeroFlags, decVec, motorDecode;
   logic                    validReq, singleReq, accept, reject;
   logic [STOCK_W-1:0]      stockCount [N_PRODUCTS];

`ifdef DISPENSER_PENDING_EN
   logic                    pendValid, pendSet, pendClear, candValid;
   prodIdx_t                pendIdx, candIdx;
`endif

   assign strobes   = {soda, torta, burguer, pizza};
   assign validReq  = sucesso && (strobes != '0);
   assign singleReq = validReq && isOneHot(strobes);
   assign reqIdx    = oneHotIndex(strobes);

   // Next state plus accept/reject decisions; stock is judged from the registered counts
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      acceptIdx = reqIdx;
      reject    = 1'b0;
`ifdef DISPENSER_PENDING_EN
      pendSet   = 1'b0;
      pendClear = 1'b0;
      candValid = 1'b0;
      candIdx   = reqIdx;
`endif
      case (state)
         IDLE: begin
            if (validReq) begin
               if (singleReq && !zeroFlags[reqIdx]) accept = 1'b1;
               else                                 reject = 1'b1;
            end
         end
         DISPENSE: begin
            if (phaseCnt == MOTOR_LAST) nextState = SETTLE;
         end
         SETTLE: begin
            if (phaseCnt == SETTLE_LAST) nextState = DONE;
         end
         DONE: begin
            nextState = IDLE;
`ifdef DISPENSER_PENDING_EN
            // An empty slot lets a request arriving during DONE be judged right away
            pendClear = 1'b1;
            candValid = pendValid || singleReq;
            candIdx   = pendValid ? pendIdx : reqIdx;
            if (validReq && (pendValid || !singleReq)) reject = 1'b1;
            if (candValid) begin
               if (!zeroFlags[candIdx]) begin
                  accept    = 1'b1;
                  acceptIdx = candIdx;
               end else begin
                  reject = 1'b1;
               end
            end
`else
            if (validReq) reject = 1'b1;
`endif
         end
         default: nextState = IDLE;
      endcase

      if (((state == DISPENSE) || (state == SETTLE)) && validReq) begin
`ifdef DISPENSER_PENDING_EN
         if (singleReq && !pendValid) pendSet = 1'b1;
         else                         reject  = 1'b1;
`else
         reject = 1'b1;
`endif
      end

      if (accept) nextState = DISPENSE;
      nextIdx     = accept ? acceptIdx : curIdx;
      motorDecode = N_PRODUCTS'(1) << nextIdx;
   end

   // State register with registered status outputs derived from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         phaseCnt <= '0;
         curIdx   <= '0;
         motor    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         erro     <= 1'b0;
      end else begin
         state <= nextState;
         if (nextState != state)                          phaseCnt <= '0;
         else if ((state == DISPENSE) || (state == SETTLE)) phaseCnt <= phaseCnt + 1'b1;
         curIdx <= nextIdx;
         motor  <= (nextState == DISPENSE) ? motorDecode : '0;
         busy   <= (nextState != IDLE);
         done   <= (nextState == DONE);
         erro   <= reject;
      end
   end

`ifdef DISPENSER_PENDING_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         pendValid <= 1'b0;
         pendIdx   <= '0;
      end else if (pendSet) begin
         pendValid <= 1'b1;
         pendIdx   <= reqIdx;
      end else if (pendClear) begin
         pendValid <= 1'b0;
      end
   end
`endif

   for (genvar g = 0; g < N_PRODUCTS; g++) begin : gStock
      assign decVec[g] = accept && (acceptIdx == prodIdx_t'(g));

      dispenser_stock_counter #(
         .STOCK_W    (STOCK_W),
         .STOCK_INIT (STOCK_INIT)
      ) uCounter (
         .clock (clock),
         .reset (reset),
         .load  (reabastecer),
         .dec   (decVec[g]),
         .count (stockCount[g]),
         .zero  (zeroFlags[g])
      );

      assign estoque[g*STOCK_W +: STOCK_W] = stockCount[g];
   end

   assign esgotado = zeroFlags;

endmodule

// File: tb/tb_food_dispenser.sv
// Self-checking bench for food_dispenser: directed scenarios followed by random
// traffic, all compared against a cycle-countdown reference model.
module tb_food_dispenser;

   localparam int M    = 4;
   localparam int S    = 2;
   localparam int INIT = 3;
   localparam int W    = 4;
   localparam int NP   = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          pizza = 1'b0, burguer = 1'b0, torta = 1'b0, soda = 1'b0;
   logic          sucesso = 1'b0, reabastecer = 1'b0;
   logic [NP-1:0] motor, esgotado;
   logic          busy, done, erro;
   logic [NP*W-1:0] estoque;

   int assertCount = 0;
   int failCount   = 0;

   // Reference model: busyLeft counts remaining busy cycles including the done cycle
   int stock [NP];
   int busyLeft  = 0;
   int curProd   = 0;
   bit pendValid = 0;
   int pendProd  = 0;
   bit expErro   = 0;

   food_dispenser #(
      .MOTOR_CYCLES  (M),
      .SETTLE_CYCLES (S),
      .STOCK_INIT    (INIT),
      .STOCK_W       (W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .pizza       (pizza),
      .burguer     (burguer),
      .torta       (torta),
      .soda        (soda),
      .sucesso     (sucesso),
      .reabastecer (reabastecer),
      .motor       (motor),
      .busy        (busy),
      .done        (done),
      .esgotado    (esgotado),
      .erro        (erro),
      .estoque     (estoque)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelStep();
      logic [3:0] s;
      bit valid, single, err;
      int ri, accIdx, cand;
      s = {soda, torta, burguer, pizza};
      valid  = sucesso && (s != 0);
      single = valid && ($countones(s) == 1);
      ri = 0;
      for (int i = 0; i < NP; i++) if (s[i]) ri = i;
      accIdx = -1;
      err    = 0;
      if (reset) begin
         busyLeft  = 0;
         pendValid = 0;
         for (int i = 0; i < NP; i++) stock[i] = INIT;
      end else begin
         if (busyLeft == 0) begin
            if (valid) begin
               if (single && stock[ri] > 0) accIdx = ri;
               else err = 1;
            end
         end
`ifdef DISPENSER_PENDING_EN
         else if (busyLeft == 1) begin
            cand = -1;
            if (pendValid) cand = pendProd;
            else if (single) cand = ri;
            if (valid && (pendValid || !single)) err = 1;
            pendValid = 0;
            if (cand >= 0) begin
               if (stock[cand] > 0) accIdx = cand;
               else err = 1;
            end
         end else if (valid) begin
            if (single && !pendValid) begin
               pendValid = 1;
               pendProd  = ri;
            end else begin
               err = 1;
            end
         end
`else
         else if (valid) err = 1;
`endif
         if (accIdx >= 0) begin
            busyLeft = M + S + 1;
            curProd  = accIdx;
         end else if (busyLeft > 0) begin
            busyLeft--;
         end
         if (reabastecer) begin
            for (int i = 0; i < NP; i++) stock[i] = (i == accIdx) ? INIT - 1 : INIT;
         end else if (accIdx >= 0) begin
            stock[accIdx]--;
         end
      end
      expErro = err;
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] s, input logic su, input logic rb);
      logic [NP*W-1:0] expStock;
      logic [NP-1:0]   expOut;
      @(negedge clock);
      reset = r;
      {soda, torta, burguer, pizza} = s;
      sucesso = su;
      reabastecer = rb;
      @(posedge clock);
      modelStep();
      #1;
      expStock = '0;
      expOut   = '0;
      for (int i = 0; i < NP; i++) begin
         expStock[i*W +: W] = W'(stock[i]);
         expOut[i] = (stock[i] == 0);
      end
      checkOutput("motor", motor, (busyLeft > S + 1) ? (32'd1 << curProd) : 32'd0);
      checkOutput("busy", busy, busyLeft > 0);
      checkOutput("done", done, busyLeft == 1);
      checkOutput("erro", erro, expErro);
      checkOutput("estoque", estoque, expStock);
      checkOutput("esgotado", esgotado, expOut);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
   endtask

   initial begin
      int expBurguer;
      logic [3:0] s;
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      checkOutput("reset_stock", estoque, 16'h3333);

      // Single pizza dispense
      applyStimulus(1'b0, 4'b0001, 1'b1, 1'b0);
      checkOutput("pizza_motor", motor, 4'b0001);
      idleCycles(M + S + 1);
      checkOutput("pizza_stock", estoque[3:0], 2);

      // Soda until sold out
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 4'b1000, 1'b1, 1'b0);
         idleCycles(M + S + 1);
      end
      checkOutput("soda_soldout", esgotado, 4'b1000);
      checkOutput("soda_stock", estoque[15:12], 0);

      // Two strobes at once
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b0101, 1'b1, 1'b0);
      checkOutput("multi_erro", erro, 1);
      checkOutput("multi_motor", motor, 0);
      checkOutput("multi_stock", estoque, 16'h3333);

      // Request during dispense
      applyStimulus(1'b0, 4'b0010, 1'b1, 1'b0);
      idleCycles(1);
      applyStimulus(1'b0, 4'b0010, 1'b1, 1'b0);
`ifdef DISPENSER_PENDING_EN
      expBurguer = 1;
      checkOutput("busy_req_erro", erro, 0);
`else
      expBurguer = 2;
      checkOutput("busy_req_erro", erro, 1);
`endif
      idleCycles(2 * (M + S + 1));
      checkOutput("busy_req_stock", estoque[7:4], expBurguer);

      // Reset mid-dispense
      applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0);
      idleCycles(1);
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      checkOutput("midreset_motor", motor, 0);
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_stock", estoque, 16'h3333);

      // Restock coinciding with a sold-out request
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 4'b1000, 1'b1, 1'b0);
         idleCycles(M + S + 1);
      end
      applyStimulus(1'b0, 4'b1000, 1'b1, 1'b1);
      checkOutput("restock_erro", erro, 1);
      checkOutput("restock_soda", estoque[15:12], 3);
      checkOutput("restock_esgotado", esgotado, 0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 6)       s = 4'b0001 << $urandom_range(0, 3);
         else if (kind == 6) s = 4'($urandom_range(1, 15));
         else                s = 4'b0000;
         applyStimulus($urandom_range(0, 99) < 2, s, $urandom_range(0, 9) < 8,
                       $urandom_range(0, 99) < 4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
